// File: rtl/switch_box_config_loader.sv
// Bit-serial configuration loader for a row of switch_box_element_two instances.
// Bits assemble MSB-first in a shadow register and reach cfg_out only on a valid commit.
module switch_box_config_loader #(
  parameter int NUM_ELEMS = 4,
  parameter int CFG_W     = 12,
  localparam int TOTAL    = NUM_ELEMS * CFG_W,
  localparam int CNT_W    = $clog2(TOTAL + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             cfg_in,
  input  logic             cfg_valid,
  output logic             cfg_ready,
  input  logic             commit,
  input  logic             clear,
  output logic [TOTAL-1:0] cfg_out,
  output logic             cfg_done,
  output logic             err,
  output logic             busy,
  output logic             shift_out
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_SHIFT = 2'd1;
  localparam logic [1:0] S_ERR   = 2'd2;

  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(TOTAL);

  logic [1:0]       r_state;
  logic [1:0]       w_state_next;
  logic [TOTAL-1:0] r_shadow;
  logic [TOTAL-1:0] w_shadow_next;
  logic [TOTAL-1:0] w_shifted;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] w_cnt_next;
  logic [CNT_W-1:0] w_cnt_inc;
  logic             r_err;
  logic             w_err_next;
  logic             r_done;
  logic             w_done_next;
  logic             w_accept;
  logic             w_overflow;
  logic             w_commit_ok;
  logic             w_load;
  logic [CFG_W-1:0] r_cfg_elem [NUM_ELEMS];

  assign cfg_ready = (r_state != S_ERR);
  assign busy      = (r_state == S_SHIFT);
  assign err       = r_err;
  assign cfg_done  = r_done;
  assign shift_out = r_shadow[TOTAL-1];

  assign w_accept    = cfg_valid && cfg_ready;
  assign w_shifted   = {r_shadow[TOTAL-2:0], cfg_in};
  assign w_cnt_inc   = w_accept ? (r_cnt + CNT_W'(1)) : r_cnt;
  assign w_commit_ok = commit && (w_cnt_inc == CNT_FULL);
  // Overflow is only policed in SHIFT; IDLE shifting is the cascade path.
  assign w_overflow  = w_accept && (r_state == S_SHIFT) && (r_cnt == CNT_FULL);

  always_comb begin
    w_state_next  = r_state;
    w_shadow_next = r_shadow;
    w_cnt_next    = r_cnt;
    w_err_next    = r_err;
    w_done_next   = 1'b0;
    w_load        = 1'b0;
    if (clear) begin
      w_state_next  = S_IDLE;
      w_shadow_next = '0;
      w_cnt_next    = '0;
      w_err_next    = 1'b0;
    end else begin
      case (r_state)
        S_IDLE, S_SHIFT: begin
          if (w_overflow) begin
            w_err_next   = 1'b1;
            w_state_next = S_ERR;
          end else begin
            if (w_accept) begin
              w_shadow_next = w_shifted;
              w_cnt_next    = w_cnt_inc;
              w_state_next  = S_SHIFT;
            end
            // A same-cycle bit is already folded into w_cnt_inc before judging the commit.
            if (commit) begin
              if (w_commit_ok) begin
                w_load       = 1'b1;
                w_done_next  = 1'b1;
                w_cnt_next   = '0;
                w_state_next = S_IDLE;
              end else begin
                w_err_next   = 1'b1;
                w_state_next = S_ERR;
              end
            end
          end
        end
        S_ERR: begin
          w_state_next = S_ERR;
        end
        default: begin
          w_state_next = S_IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= S_IDLE;
      r_shadow <= '0;
      r_cnt    <= '0;
      r_err    <= 1'b0;
      r_done   <= 1'b0;
    end else begin
      r_state  <= w_state_next;
      r_shadow <= w_shadow_next;
      r_cnt    <= w_cnt_next;
      r_err    <= w_err_next;
      r_done   <= w_done_next;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_ELEMS; i++) begin
        r_cfg_elem[i] <= '0;
      end
    end else if (w_load) begin
      for (int i = 0; i < NUM_ELEMS; i++) begin
        r_cfg_elem[i] <= w_shadow_next[i*CFG_W +: CFG_W];
      end
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < NUM_ELEMS; gi++) begin : g_elem_out
      assign cfg_out[gi*CFG_W +: CFG_W] = r_cfg_elem[gi];
    end
  endgenerate

endmodule

// File: tb/tb_switch_box_config_loader.sv
// Directed and randomized checks of switch_box_config_loader against a
// frame-level reference model (bit queue packed MSB-first on commit).
module tb_switch_box_config_loader;

  localparam int NUM_ELEMS = 4;
  localparam int CFG_W     = 12;
  localparam int TOTAL     = NUM_ELEMS * CFG_W;

  logic             clk;
  logic             rst_n;
  logic             cfg_in;
  logic             cfg_valid;
  logic             cfg_ready;
  logic             commit;
  logic             clear;
  logic [TOTAL-1:0] cfg_out;
  logic             cfg_done;
  logic             err;
  logic             busy;
  logic             shift_out;

  int n_checks = 0;
  int n_errors = 0;

  // Reference model: pending bits and the last value that should be active.
  bit               model_q[$];
  logic [TOTAL-1:0] model_out;

  switch_box_config_loader #(
    .NUM_ELEMS(NUM_ELEMS),
    .CFG_W    (CFG_W)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .cfg_in   (cfg_in),
    .cfg_valid(cfg_valid),
    .cfg_ready(cfg_ready),
    .commit   (commit),
    .clear    (clear),
    .cfg_out  (cfg_out),
    .cfg_done (cfg_done),
    .err      (err),
    .busy     (busy),
    .shift_out(shift_out)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [TOTAL-1:0] obs, input logic [TOTAL-1:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [TOTAL-1:0] pack_queue();
    logic [TOTAL-1:0] v;
    v = '0;
    foreach (model_q[i]) v = (v << 1) | TOTAL'(model_q[i]);
    return v;
  endfunction

  task automatic step(input logic v, input logic b, input logic c, input logic clr);
    cfg_valid = v;
    cfg_in    = b;
    commit    = c;
    clear     = clr;
    @(posedge clk);
    #1;
    cfg_valid = 1'b0;
    cfg_in    = 1'b0;
    commit    = 1'b0;
    clear     = 1'b0;
  endtask

  // Send a whole frame MSB-first and commit it, separately or with the last bit.
  task automatic send_frame(input logic [TOTAL-1:0] f, input bit merge_commit, input bit gaps);
    logic [TOTAL-1:0] exp;
    model_q.delete();
    for (int i = 0; i < TOTAL; i++) begin
      if (gaps && $urandom_range(0, 3) == 0) step(1'b0, 1'b0, 1'b0, 1'b0);
      model_q.push_back(f[TOTAL-1-i]);
      step(1'b1, f[TOTAL-1-i], merge_commit && (i == TOTAL-1), 1'b0);
      if (i == TOTAL/2) chk("stable_mid_frame", cfg_out, model_out);
    end
    if (!merge_commit) step(1'b0, 1'b0, 1'b1, 1'b0);
    exp = pack_queue();
    model_out = exp;
    chk("commit_out", cfg_out, exp);
    chk("commit_done", TOTAL'(cfg_done), TOTAL'(1'b1));
    chk("commit_err", TOTAL'(err), '0);
    chk("commit_idle", TOTAL'(busy), '0);
  endtask

  initial begin
    logic [TOTAL-1:0] f;
    logic [TOTAL-1:0] f_prev;
    logic [CFG_W-1:0] a5c;

    rst_n     = 1'b1;
    cfg_in    = 1'b0;
    cfg_valid = 1'b0;
    commit    = 1'b0;
    clear     = 1'b0;
    model_out = '0;
    a5c       = 12'hA5C;

    #2 rst_n = 1'b0;
    #1;
    chk("rst_cfg_out", cfg_out, '0);
    chk("rst_err", TOTAL'(err), '0);
    chk("rst_busy", TOTAL'(busy), '0);
    chk("rst_done", TOTAL'(cfg_done), '0);
    chk("rst_shift_out", TOTAL'(shift_out), '0);
    #9 rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk("ready_after_rst", TOTAL'(cfg_ready), TOTAL'(1'b1));

    // Basic load: element 3 carries 12'hA5C.
    f = {a5c, 36'h012345678};
    send_frame(f, 1'b0, 1'b0);
    chk("basic_elem3", TOTAL'(cfg_out[3*CFG_W +: CFG_W]), TOTAL'(a5c));
    step(1'b0, 1'b0, 1'b0, 1'b0);
    chk("done_one_cycle", TOTAL'(cfg_done), '0);
    chk("hold_after_commit", cfg_out, model_out);

    // Last bit and commit together.
    f = {a5c, TOTAL'($urandom)};
    f[TOTAL-CFG_W-1 -: 32] = $urandom;
    send_frame(f, 1'b1, 1'b0);
    f_prev = f;

    // Short frame then commit.
    for (int i = 0; i < TOTAL-1; i++) step(1'b1, 1'($urandom_range(0, 1)), 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b1, 1'b0);
    chk("short_err", TOTAL'(err), TOTAL'(1'b1));
    chk("short_ready", TOTAL'(cfg_ready), '0);
    chk("short_out_kept", cfg_out, f_prev);
    step(1'b1, 1'b1, 1'b1, 1'b0);
    chk("err_ignores_commit", cfg_out, f_prev);
    chk("err_sticky", TOTAL'(err), TOTAL'(1'b1));
    step(1'b0, 1'b0, 1'b0, 1'b1);
    chk("clear_err", TOTAL'(err), '0);
    chk("clear_ready", TOTAL'(cfg_ready), TOTAL'(1'b1));
    chk("clear_idle", TOTAL'(busy), '0);
    chk("clear_shadow", TOTAL'(shift_out), '0);
    send_frame({$urandom, $urandom}, 1'b0, 1'b0);

    // Commit with no bits loaded.
    step(1'b0, 1'b0, 1'b1, 1'b0);
    chk("empty_commit_err", TOTAL'(err), TOTAL'(1'b1));
    step(1'b0, 1'b0, 1'b0, 1'b1);

    // Overflow: 49th bit must be dropped, so the MSB stays the first bit.
    f = {$urandom, $urandom};
    f[TOTAL-1] = 1'b1;
    f[TOTAL-2] = 1'b0;
    for (int i = 0; i < TOTAL; i++) step(1'b1, f[TOTAL-1-i], 1'b0, 1'b0);
    chk("full_no_err", TOTAL'(err), '0);
    chk("full_busy", TOTAL'(busy), TOTAL'(1'b1));
    chk("full_msb", TOTAL'(shift_out), TOTAL'(1'b1));
    step(1'b1, 1'b0, 1'b0, 1'b0);
    chk("ovf_err", TOTAL'(err), TOTAL'(1'b1));
    chk("ovf_not_shifted", TOTAL'(shift_out), TOTAL'(1'b1));
    chk("ovf_out_kept", cfg_out, model_out);
    step(1'b0, 1'b0, 1'b0, 1'b1);

    // Reset in the middle of a frame acts without a clock edge.
    send_frame('1, 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) step(1'b1, 1'b1, 1'b0, 1'b0);
    #3 rst_n = 1'b0;
    #1;
    model_out = '0;
    chk("midrst_out", cfg_out, '0);
    chk("midrst_done", TOTAL'(cfg_done), '0);
    chk("midrst_err", TOTAL'(err), '0);
    chk("midrst_busy", TOTAL'(busy), '0);
    chk("midrst_shadow", TOTAL'(shift_out), '0);
    #2 rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Randomized back-to-back frames.
    for (int n = 0; n < 100; n++) begin
      f = {$urandom, $urandom};
      send_frame(f, 1'($urandom_range(0, 1)), 1'b1);
      for (int k = 0; k < NUM_ELEMS; k++) begin
        chk("rand_slice", TOTAL'(cfg_out[k*CFG_W +: CFG_W]), TOTAL'(f[k*CFG_W +: CFG_W]));
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/switch_box_config_loader.md
# switch_box_config_loader

Serial configuration loader that sits directly upstream of a row of `switch_box_element_two` instances and drives their 12-bit `c` configuration inputs. It accepts a bit-serial bitstream with a valid/ready handshake and assembles it in a shadow register. It then commits the whole word atomically to the active configuration outputs, so that switch boxes never see a partially loaded pattern. Length mismatches are flagged as sticky errors, and a daisy-chain output lets several loaders be cascaded.

## Interface
- `NUM_ELEMS`, default 4: number of switch box elements configured.
- `CFG_W`, default 12: configuration bits per element; must stay 12 for `switch_box_element_two`.
- Derived `TOTAL = NUM_ELEMS*CFG_W`.
- Derived `CNT_W = $clog2(TOTAL+1)`.

Ports:
- `clk`  in  1  single clock; all state is updated on the rising edge.
- `rst_n`  in  1  reset, asynchronous and active-low.
- `cfg_in`  in  1  serial configuration bit.
- `cfg_valid`  in  1  `cfg_in` is valid this cycle.
- `cfg_ready`  out  1  loader accepts a bit this cycle.
- `commit`  in  1  request to transfer the shadow register to `cfg_out`.
- `clear`  in  1  leave the ERR state; clear the shadow register and bit count.
- `cfg_out`  out  TOTAL  active configuration; element k uses `cfg_out[CFG_W*k+CFG_W-1 : CFG_W*k]`.
- `cfg_done`  out  1  one-cycle pulse on a successful commit.
- `err`  out  1  sticky length error.
- `busy`  out  1  state is SHIFT.
- `shift_out`  out  1  shadow MSB, for daisy-chaining to the next loader.

## Operation
- **State set:** IDLE, SHIFT, ERR.
- **Handshake:**
  - A bit is accepted on any edge where `cfg_valid && cfg_ready`.
  - `cfg_ready = 1` in IDLE and SHIFT, and 0 in ERR.
  - An accepted bit shifts in at the LSB: `shadow <= {shadow[TOTAL-2:0], cfg_in}`.
  - The first bit sent therefore ends up at `cfg_out[TOTAL-1]` (MSB-first).
  - An accepted bit increments `cnt`.
- **`cnt_next`:** `cnt` plus 1 if a bit is accepted this cycle, otherwise `cnt`.
- **IDLE:**
  - An accepted bit moves the state to SHIFT.
  - `commit` with `cnt_next == TOTAL` performs a commit and stays in IDLE.
  - `commit` with any other `cnt_next` (including 0) moves the state to ERR.
- **SHIFT:**
  - An accepted bit while `cnt == TOTAL` is an overflow: the bit is not shifted, `err` is set, and the state moves to ERR.
  - `commit` with `cnt_next == TOTAL` performs a commit: `cfg_out <= shadow_next`, `cfg_done <= 1`, `cnt <= 0`, and the state returns to IDLE.
  - `commit` with `cnt_next != TOTAL` sets `err` and moves the state to ERR.
  - Valid and commit in the same cycle: the bit is shifted first and the commit is judged on `cnt_next`.
- **ERR:**
  - Bits are not accepted and `commit` is ignored.
  - `cfg_out` keeps its last committed value.
  - `clear` sets `shadow <= 0`, `cnt <= 0`, `err <= 0`, and the state moves to IDLE.
  - `clear` in IDLE or SHIFT also zeroes `shadow` and `cnt`, and the state moves to IDLE. `clear` has priority over `cfg_valid` and `commit`.
- **`cfg_out` stability:** `cfg_out` changes only on a successful commit or on reset, never during shifting.
- **`shift_out`:** equals `shadow[TOTAL-1]` (registered). Once a full frame is resident, each further accepted bit would push the oldest bit out to the next loader. Overflow is checked only in SHIFT, so cascading uses IDLE-state shifting, where there is no overflow check.

## Timing
- **Reset values** (asynchronous, taking effect immediately on `rst_n = 0`):
  - state IDLE;
  - `shadow = 0`, `cnt = 0`;
  - `cfg_out = 0`, i.e. all switches open;
  - `cfg_done = 0`, `err = 0`, `busy = 0`;
  - `shift_out = 0`, `cfg_ready = 1` once reset is released.
- **Reset mid-shift:** discards the partial frame; `cfg_out` goes to 0.
- **Shift latency:** a bit accepted at edge T is visible in `shadow` after T.
- **Commit latency:** for a commit accepted at edge T, `cfg_out` holds the new value after T. `cfg_done` is high for exactly the cycle following T, aligned with the new `cfg_out`.
- **Error latency:** `err` rises the cycle after the offending edge and holds until `clear` or reset.
- **Back-to-back frames:** a commit may be followed by the first bit of the next frame on the very next edge; there are no dead cycles.
- **Output decode:** `busy` and `cfg_ready` are combinational decodes of the state register.

## Test plan
- **Basic load:** `NUM_ELEMS=1`; shift `12'hA5C` MSB-first with `cfg_valid` held high, then `commit` on the next cycle. Expect `cfg_out = 12'hA5C`, `cfg_done` high for 1 cycle, state IDLE, and the driven switch box connecting exactly the pairs selected by `c = 12'hA5C`.
- **Simultaneous last bit and commit:** 11 bits, then the 12th bit with `commit` in the same cycle. Expect a commit, `cfg_out = 12'hA5C`, `err = 0`.
- **Short frame:** 11 bits, then `commit`. Expect `err = 1`, `cfg_ready = 0`, `cfg_out` unchanged from the previous value. Then `clear`: expect `err = 0`, IDLE, `cnt = 0`.
- **Overflow:** 13 bits without commit. Expect `err = 1` the cycle after the 13th accept, and `shadow` still equal to the first 12 bits.
- **Reset mid-operation:** load and commit `12'hFFF`, shift 5 bits of a new frame, then pulse `rst_n` low. Expect `cfg_out = 0`, `cnt = 0`, `cfg_done = 0`, `err = 0` immediately, without waiting for a clock edge.
- **Multi-element and randomized:** `NUM_ELEMS=4`; 100 random 48-bit frames, each committed. Expect `cfg_out` slice k to equal frame bits `[12k+11:12k]` every time, with zero mismatches counted by the scoreboard.
